vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
Parametrised VGA/raster timing generator. Successor to the fixed 640x480 timing block: all porch/sync/active lengths, sync polarities and the pixel-clock divide ratio are parameters. Adds a hold-enable input and registered pixel, line and frame strobes. Drives the pixel data generators and the DAC sync pins from the single system clock.

Parameters:
HACTIVE, 640, visible pixels per line
HFRONT, 16, horizontal front porch (pixels)
HSYNC, 96, horizontal sync width (pixels)
HBACK, 48, horizontal back porch (pixels)
VACTIVE, 480, visible lines per frame
VFRONT, 10, vertical front porch (lines)
VSYNC, 2, vertical sync width (lines)
VBACK, 33, vertical back porch (lines)
HSYNC_POL, 0, asserted level of hSync (0 = active-low)
VSYNC_POL, 0, asserted level of vSync
PCLK_DIV, 2, clk50 cycles per pixel (>=1)
HW / VW, 10 / 10, counter widths; must hold HTOTAL-1 / VTOTAL-1

Ports:
clk50  in  1  system clock
reset  in  1  synchronous reset, active-low (reset==0 resets)
en  in  1  1 = timing runs; 0 = freeze all counters and outputs
pixEn  out  1  one-clk50 strobe per pixel period
hSync  out  1  horizontal sync, polarity per HSYNC_POL
vSync  out  1  vertical sync, polarity per VSYNC_POL
active  out  1  current pixel visible
col  out  HW  current column; 0 outside active
row  out  VW  current row; 0 outside active
col0  out  1  strobe: line start (hCount became 0)
row0  out  1  strobe: frame start (hCount and vCount became 0)
frameCnt  out  16  frame counter (only with VGA_FRAME_CNT_EN)

Behaviour:
- HTOTAL = HACTIVE+HFRONT+HSYNC+HBACK (800); VTOTAL likewise (525).
- Line order: active [0,HACTIVE), front porch, sync, back porch; same for frame.
- Divider divCnt counts 0..PCLK_DIV-1, wraps; pixEn registered, high in the cycle after divCnt==PCLK_DIV-1. PCLK_DIV=1: pixEn permanently 1 while en.
- On each pixEn: hCount increments; at HTOTAL-1 wraps to 0 and vCount increments; vCount wraps at VTOTAL-1.
- All outputs registered, decoded from next-state counters, so they change in the same cycle the counters move (no combinational glitches).
- hSync asserted iff HACTIVE+HFRONT <= hCount < HACTIVE+HFRONT+HSYNC; vSync analogously on vCount (whole lines, no half-line offset).
- active = (hCount<HACTIVE)&(vCount<VACTIVE); col/row = counters when active, else 0.
- col0 high one clk50 cycle, in the cycle hCount becomes 0; row0 same cycle, only when vCount also becomes 0.
- en=0: divCnt, counters, sync/active/col/row hold; pixEn, col0, row0 forced 0. Resume continues from held position, no skipped pixel.
- Reset: divCnt=0, hCount=HTOTAL-1, vCount=VTOTAL-1; pixEn=col0=row0=0, active=0, col=row=0, hSync=vSync=deasserted, frameCnt=0. First pixEn after release wraps to (0,0) and fires col0+row0.
- Reset mid-frame: next clk50 edge with reset==0 applies reset values regardless of en.
- Elaboration check: HTOTAL-1 fits HW, VTOTAL-1 fits VW, PCLK_DIV>=1, all porch/sync >=1; else $error.

Optional Feature:
VGA_FRAME_CNT_EN defined: frameCnt port exists; increments by 1 (mod 2^16) in the cycle row0 asserts; reset to 0. Undefined: port and counter omitted; all other behaviour identical.

Test Plan:
Defaults, release reset, en=1 -> first pixEn 2 clk50 cycles after release with col0=row0=1, active=1, col=0,row=0; pixEn period exactly 2 cycles thereafter.
Defaults, one full line -> col0 period 1600 clk50; hSync low for 192 cycles from hCount=656 to 751; active high for 1280 cycles.
Defaults, one full frame -> row0 period 840000 clk50; vSync low for exactly 2 lines (3200 cycles) starting vCount=490; row=479 on last active line then 0.
en dropped at hCount=300,vCount=100 for 50 cycles -> pixEn/col0 stay 0, col=300,row=100 held; on resume next pixel is col=301.
reset=0 asserted at hCount=700 (inside sync) -> next cycle hSync deasserted, active=0, col=row=0; restart as test 1.
PCLK_DIV=1, HACTIVE=8,HFRONT=2,HSYNC=3,HBACK=2, VACTIVE=4,VFRONT=1,VSYNC=1,VBACK=1, VGA_FRAME_CNT_EN -> col0 every 15 cycles, row0 every 105, frameCnt 0->1->2 on successive row0.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Bundle between the raster timing generator and its consumers: run-enable in, strobes/syncs/coordinates out.
// frameCnt is present only when VGA_FRAME_CNT_EN is defined.
interface vga_timing_gen_if #(
    parameter int HW = 10,
    parameter int VW = 10
);
    logic          en;
    logic          pixEn;
    logic          hSync;
    logic          vSync;
    logic          active;
    logic [HW-1:0] col;
    logic [VW-1:0] row;
    logic          col0;
    logic          row0;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0]   frameCnt;
`endif

    modport master (
        input  en,
        output pixEn, hSync, vSync, active, col, row, col0, row0
`ifdef VGA_FRAME_CNT_EN
        , output frameCnt
`endif
    );

    modport slave (
        output en,
        input  pixEn, hSync, vSync, active, col, row, col0, row0
`ifdef VGA_FRAME_CNT_EN
        , input frameCnt
`endif
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/raster timing generator: pixel-clock divider, h/v counters, registered syncs and strobes.
// Optional frame counter on the bus when VGA_FRAME_CNT_EN is defined.
module vga_timing_gen #(
    parameter int HACTIVE   = 640,
    parameter int HFRONT    = 16,
    parameter int HSYNC     = 96,
    parameter int HBACK     = 48,
    parameter int VACTIVE   = 480,
    parameter int VFRONT    = 10,
    parameter int VSYNC     = 2,
    parameter int VBACK     = 33,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int PCLK_DIV  = 2,
    parameter int HW        = 10,
    parameter int VW        = 10
) (
    input  logic              clk50,
    input  logic              reset,
    vga_timing_gen_if.master  bus
);
    localparam int   HTOTAL = HACTIVE + HFRONT + HSYNC + HBACK;
    localparam int   VTOTAL = VACTIVE + VFRONT + VSYNC + VBACK;
    localparam int   DW     = (PCLK_DIV > 1) ? $clog2(PCLK_DIV) : 1;
    localparam logic HS_ON  = (HSYNC_POL != 0);
    localparam logic VS_ON  = (VSYNC_POL != 0);

    if (HTOTAL - 1 >= (1 << HW)) begin : g_hw_chk
        $error("vga_timing_gen: HTOTAL-1 does not fit in HW bits");
    end
    if (VTOTAL - 1 >= (1 << VW)) begin : g_vw_chk
        $error("vga_timing_gen: VTOTAL-1 does not fit in VW bits");
    end
    if (PCLK_DIV < 1) begin : g_div_chk
        $error("vga_timing_gen: PCLK_DIV must be at least 1");
    end
    if (HFRONT < 1 || HSYNC < 1 || HBACK < 1 || VFRONT < 1 || VSYNC < 1 || VBACK < 1) begin : g_porch_chk
        $error("vga_timing_gen: porch and sync widths must be at least 1");
    end

    logic [DW-1:0] div_cnt;
    logic [HW-1:0] h_count;
    logic [HW-1:0] h_next;
    logic [VW-1:0] v_count;
    logic [VW-1:0] v_next;
    logic          pix_tick;
    logic          h_act_next;
    logic          v_act_next;
    logic          hs_next;
    logic          vs_next;

    // Next counter position; outputs are decoded from it so they move in the same cycle as the counters.
    always_comb begin
        pix_tick = (div_cnt == DW'(PCLK_DIV - 1));
        h_next   = h_count;
        v_next   = v_count;
        if (pix_tick) begin
            if (h_count == HW'(HTOTAL - 1)) begin
                h_next = '0;
                if (v_count == VW'(VTOTAL - 1)) begin
                    v_next = '0;
                end else begin
                    v_next = v_count + 1'b1;
                end
            end else begin
                h_next = h_count + 1'b1;
            end
        end
        h_act_next = (h_next < HW'(HACTIVE));
        v_act_next = (v_next < VW'(VACTIVE));
        hs_next    = (h_next >= HW'(HACTIVE + HFRONT)) && (h_next < HW'(HACTIVE + HFRONT + HSYNC));
        vs_next    = (v_next >= VW'(VACTIVE + VFRONT)) && (v_next < VW'(VACTIVE + VFRONT + VSYNC));
    end

    // Counters parked at the last position so the first pixel after reset wraps to (0,0) and fires both strobes.
    always_ff @(posedge clk50) begin
        if (!reset) begin
            div_cnt    <= '0;
            h_count    <= HW'(HTOTAL - 1);
            v_count    <= VW'(VTOTAL - 1);
            bus.pixEn  <= 1'b0;
            bus.col0   <= 1'b0;
            bus.row0   <= 1'b0;
            bus.active <= 1'b0;
            bus.col    <= '0;
            bus.row    <= '0;
            bus.hSync  <= ~HS_ON;
            bus.vSync  <= ~VS_ON;
`ifdef VGA_FRAME_CNT_EN
            bus.frameCnt <= 16'd0;
`endif
        end else if (bus.en) begin
            div_cnt    <= pix_tick ? '0 : div_cnt + 1'b1;
            h_count    <= h_next;
            v_count    <= v_next;
            bus.pixEn  <= pix_tick;
            bus.col0   <= pix_tick && (h_next == '0);
            bus.row0   <= pix_tick && (h_next == '0) && (v_next == '0);
            bus.active <= h_act_next && v_act_next;
            bus.col    <= (h_act_next && v_act_next) ? h_next : '0;
            bus.row    <= (h_act_next && v_act_next) ? v_next : '0;
            bus.hSync  <= hs_next ? HS_ON : ~HS_ON;
            bus.vSync  <= vs_next ? VS_ON : ~VS_ON;
`ifdef VGA_FRAME_CNT_EN
            if (pix_tick && (h_next == '0) && (v_next == '0)) begin
                bus.frameCnt <= bus.frameCnt + 16'd1;
            end
`endif
        end else begin
            bus.pixEn <= 1'b0;
            bus.col0  <= 1'b0;
            bus.row0  <= 1'b0;
        end
    end
endmodule
